// File: rtl/img_pkg.sv
// Shared constants for the image-processing controller: frame geometry,
// algorithm and status codes, and controller state encodings.
package img_pkg;

  localparam int FB_WIDTH  = 640;
  localparam int FB_HEIGHT = 480;
  localparam int SRC_WIDTH = 160;

  localparam logic [1:0] ALG_NN  = 2'b00;
  localparam logic [1:0] ALG_PR  = 2'b01;
  localparam logic [1:0] ALG_DEC = 2'b10;
  localparam logic [1:0] ALG_BA  = 2'b11;

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORT   = 2'b10;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLEAR  = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

endpackage

// File: rtl/fb_write_mux.sv
// Registered framebuffer write port: the clear counter while clearing, or the
// bounds-checked datapath write while running. Idle cycles drive zeros.
module fb_write_mux
  import img_pkg::*;
#(
  parameter int         FB_SIZE     = FB_WIDTH * FB_HEIGHT,
  parameter logic [7:0] CLEAR_VALUE = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_sel_i,
  input  logic [18:0] clr_addr_i,
  input  logic        run_sel_i,
  input  logic [18:0] proc_addr_i,
  input  logic [7:0]  proc_pixel_i,
  output logic        ram_we_o,
  output logic [18:0] ram_wr_addr_o,
  output logic [7:0]  ram_wr_data_o
);

  localparam logic [19:0] FB_LIMIT = 20'(FB_SIZE);

  logic        ram_we_q, ram_we_d;
  logic [18:0] ram_wr_addr_q, ram_wr_addr_d;
  logic [7:0]  ram_wr_data_q, ram_wr_data_d;
  logic        in_range;

  assign in_range = ({1'b0, proc_addr_i} < FB_LIMIT);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    ram_we_d      = 1'b0;
    ram_wr_addr_d = '0;
    ram_wr_data_d = '0;
    if (clear_sel_i) begin
      ram_we_d      = 1'b1;
      ram_wr_addr_d = clr_addr_i;
      ram_wr_data_d = CLEAR_VALUE;
    end else if (run_sel_i && in_range) begin
      ram_we_d      = 1'b1;
      ram_wr_addr_d = proc_addr_i;
      ram_wr_data_d = proc_pixel_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram_we_q      <= 1'b0;
      ram_wr_addr_q <= '0;
      ram_wr_data_q <= '0;
    end else begin
      ram_we_q      <= ram_we_d;
      ram_wr_addr_q <= ram_wr_addr_d;
      ram_wr_data_q <= ram_wr_data_d;
    end
  end

  assign ram_we_o      = ram_we_q;
  assign ram_wr_addr_o = ram_wr_addr_q;
  assign ram_wr_data_o = ram_wr_data_q;

endmodule

// File: rtl/image_proc_controller.sv
// Per-frame sequencer for the scaling datapath: validate command, clear the
// framebuffer, restart and run the datapath under a watchdog, report status.
module image_proc_controller
  import img_pkg::*;
#(
  parameter int         FB_SIZE        = FB_WIDTH * FB_HEIGHT,
  parameter bit         CLEAR_EN       = 1'b1,
  parameter logic [7:0] CLEAR_VALUE    = 8'h00,
  parameter int         MAX_ZOOM       = 2,
  parameter int         TIMEOUT_CYCLES = 2000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_alg,
  input  logic [2:0]  cmd_zoom,
  input  logic        abort,
  output logic        proc_enable,
  output logic [1:0]  proc_alg,
  output logic [2:0]  proc_zoom,
  input  logic [7:0]  proc_pixel,
  input  logic [18:0] proc_write_addr,
  input  logic        proc_done,
  output logic        ram_we,
  output logic [18:0] ram_wr_addr,
  output logic [7:0]  ram_wr_data,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  status,
  output logic        cmd_err
);

  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [18:0]     CLR_LAST = 19'(FB_SIZE - 1);
  localparam logic [2:0]      ZOOM_MAX = 3'(MAX_ZOOM);

  logic [2:0]      state_q, state_d;
  logic [18:0]     clr_cnt_q, clr_cnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [1:0]      alg_q, alg_d;
  logic [2:0]      zoom_q, zoom_d;
  logic [1:0]      status_q, status_d;
  logic            cmd_err_q, cmd_err_d;
  logic            frame_done_q, proc_enable_q;
  logic            accept, zoom_ok;

  assign accept  = cmd_valid && (state_q == S_IDLE);
  assign zoom_ok = (cmd_zoom != 3'd0) && (cmd_zoom <= ZOOM_MAX);

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    wd_d      = wd_q;
    alg_d     = alg_q;
    zoom_d    = zoom_q;
    status_d  = status_q;
    cmd_err_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (zoom_ok) begin
            alg_d     = cmd_alg;
            zoom_d    = cmd_zoom;
            status_d  = ST_OK;
            clr_cnt_d = '0;
            state_d   = CLEAR_EN ? S_CLEAR : S_LAUNCH;
          end else begin
            cmd_err_d = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d = S_LAUNCH;
        end else begin
          clr_cnt_d = clr_cnt_q + 19'd1;
        end
      end
      S_LAUNCH: begin
        wd_d = '0;
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // Priority: abort, then completion, then watchdog expiry.
        if (abort) begin
          state_d  = S_DONE;
          status_d = ST_ABORT;
        end else if (proc_done) begin
          state_d  = S_DONE;
          status_d = ST_OK;
        end else if (wd_q == WD_LAST) begin
          state_d  = S_DONE;
          status_d = ST_TIMEOUT;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      clr_cnt_q     <= '0;
      wd_q          <= '0;
      alg_q         <= '0;
      zoom_q        <= '0;
      status_q      <= ST_OK;
      cmd_err_q     <= 1'b0;
      frame_done_q  <= 1'b0;
      proc_enable_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      clr_cnt_q     <= clr_cnt_d;
      wd_q          <= wd_d;
      alg_q         <= alg_d;
      zoom_q        <= zoom_d;
      status_q      <= status_d;
      cmd_err_q     <= cmd_err_d;
      frame_done_q  <= (state_d == S_DONE);
      proc_enable_q <= (state_d == S_RUN);
    end
  end

  // Datapath writes are taken only in RUN cycles that stay in RUN, so nothing lands in DONE.
  fb_write_mux #(
    .FB_SIZE    (FB_SIZE),
    .CLEAR_VALUE(CLEAR_VALUE)
  ) u_fb_write_mux (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear_sel_i  (state_d == S_CLEAR),
    .clr_addr_i   (clr_cnt_d),
    .run_sel_i    ((state_q == S_RUN) && (state_d == S_RUN)),
    .proc_addr_i  (proc_write_addr),
    .proc_pixel_i (proc_pixel),
    .ram_we_o     (ram_we),
    .ram_wr_addr_o(ram_wr_addr),
    .ram_wr_data_o(ram_wr_data)
  );

  assign cmd_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign proc_enable = proc_enable_q;
  assign proc_alg    = alg_q;
  assign proc_zoom   = zoom_q;
  assign frame_done  = frame_done_q;
  assign status      = status_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_image_proc_controller.sv
// Directed bench for image_proc_controller with a 64-pixel framebuffer and
// a 120-cycle watchdog; inputs driven and outputs sampled on the falling edge.
module tb_image_proc_controller;
  import img_pkg::*;

  localparam int FB = 64;
  localparam int TO = 120;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid, cmd_ready;
  logic [1:0]  cmd_alg;
  logic [2:0]  cmd_zoom;
  logic        abort;
  logic        proc_enable;
  logic [1:0]  proc_alg;
  logic [2:0]  proc_zoom;
  logic [7:0]  proc_pixel;
  logic [18:0] proc_write_addr;
  logic        proc_done;
  logic        ram_we;
  logic [18:0] ram_wr_addr;
  logic [7:0]  ram_wr_data;
  logic        busy, frame_done, cmd_err;
  logic [1:0]  status;

  int n_tests = 0;
  int n_fail  = 0;

  image_proc_controller #(
    .FB_SIZE(FB), .CLEAR_EN(1'b1), .CLEAR_VALUE(8'h00), .MAX_ZOOM(2), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_alg(cmd_alg), .cmd_zoom(cmd_zoom), .abort(abort),
    .proc_enable(proc_enable), .proc_alg(proc_alg), .proc_zoom(proc_zoom),
    .proc_pixel(proc_pixel), .proc_write_addr(proc_write_addr), .proc_done(proc_done),
    .ram_we(ram_we), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .busy(busy), .frame_done(frame_done), .status(status), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic       valid;
    logic [1:0] alg;
    logic [2:0] zoom;
    logic       exp_err;
  } cmd_vec_t;

  typedef struct {
    logic [18:0] addr;
    logic [7:0]  pix;
    logic        exp_we;
  } wr_vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {proc_enable, proc_alg, proc_zoom, ram_we, ram_wr_addr, ram_wr_data,
                 frame_done, status, cmd_err, busy}, 64'd0);
    check({name, "_ready"}, cmd_ready, 1);
  endtask

  // Entered on the first CLEAR cycle; leaves on LAUNCH, or DONE when aborted.
  task automatic clear_phase(input int abort_at);
    int bad;
    int n;
    bad = 0;
    n = (abort_at >= 0) ? abort_at + 1 : FB;
    for (int i = 0; i < n; i++) begin
      if (!(ram_we === 1'b1 && ram_wr_addr === 19'(i) && ram_wr_data === 8'h00 &&
            cmd_ready === 1'b0 && busy === 1'b1 && proc_enable === 1'b0)) bad++;
      if (i == abort_at) abort = 1'b1;
      @(negedge clk);
    end
    check("clear_writes", bad, 0);
  endtask

  task automatic launch_phase();
    check("launch", {busy, proc_enable, ram_we, frame_done}, {1'b1, 1'b0, 1'b0, 1'b0});
    @(negedge clk);
  endtask

  cmd_vec_t cmd_tab[5];
  wr_vec_t  wr_tab[5];

  initial begin
    int bad;
    int cyc;

    cmd_tab[0] = '{1'b1, ALG_BA,  3'd0, 1'b1};
    cmd_tab[1] = '{1'b1, ALG_DEC, 3'd3, 1'b1};
    cmd_tab[2] = '{1'b1, ALG_PR,  3'd7, 1'b1};
    cmd_tab[3] = '{1'b0, ALG_BA,  3'd2, 1'b0};
    cmd_tab[4] = '{1'b1, ALG_PR,  3'd4, 1'b1};

    wr_tab[0] = '{19'd62, 8'hAA, 1'b1};
    wr_tab[1] = '{19'd63, 8'h55, 1'b1};
    wr_tab[2] = '{19'd64, 8'h11, 1'b0};
    wr_tab[3] = '{19'd65, 8'h22, 1'b0};
    wr_tab[4] = '{19'd7,  8'h3C, 1'b1};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_alg = '0; cmd_zoom = '0; abort = 1'b0;
    proc_pixel = '0; proc_write_addr = 19'd200; proc_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // Frame A: full clear, launch, 100 RUN cycles, normal completion.
    cmd_valid = 1'b1; cmd_alg = ALG_NN; cmd_zoom = 3'd1;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cfg_a", {proc_alg, proc_zoom, busy}, {ALG_NN, 3'd1, 1'b1});
    clear_phase(-1);
    launch_phase();
    bad = 0;
    for (int c = 1; c <= 100; c++) begin
      if (!(proc_enable === 1'b1 && ram_we === 1'b0 && frame_done === 1'b0)) bad++;
      if (c == 100) proc_done = 1'b1;
      @(negedge clk);
    end
    check("run_a_enable", bad, 0);
    check("done_a", {frame_done, status, proc_enable, ram_we, busy},
          {1'b1, ST_OK, 1'b0, 1'b0, 1'b1});
    proc_done = 1'b0;
    @(negedge clk);
    check("idle_a", {frame_done, busy, status, cmd_ready}, {1'b0, 1'b0, ST_OK, 1'b1});

    // Rejected / absent commands while idle.
    foreach (cmd_tab[i]) begin
      cmd_valid = cmd_tab[i].valid; cmd_alg = cmd_tab[i].alg; cmd_zoom = cmd_tab[i].zoom;
      @(negedge clk);
      check($sformatf("cmd_err_%0d", i), {cmd_err, busy, proc_alg, proc_zoom},
            {cmd_tab[i].exp_err, 1'b0, ALG_NN, 3'd1});
      cmd_valid = 1'b0;
      @(negedge clk);
      check($sformatf("cmd_err_pulse_%0d", i), {cmd_err, busy}, {1'b0, 1'b0});
    end

    // Frame B: abort while the clear counter is at 10.
    cmd_valid = 1'b1; cmd_alg = ALG_BA; cmd_zoom = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("cfg_b", {proc_alg, proc_zoom}, {ALG_BA, 3'd2});
    clear_phase(10);
    check("abort_done", {frame_done, status, ram_we, proc_enable}, {1'b1, ST_ABORT, 1'b0, 1'b0});
    abort = 1'b0;
    @(negedge clk);
    check("abort_idle", {busy, frame_done, status, ram_we}, {1'b0, 1'b0, ST_ABORT, 1'b0});

    // Frame C: cmd_valid held through the clear, then RUN bounds checks, then reset mid-RUN.
    cmd_valid = 1'b1; cmd_alg = ALG_PR; cmd_zoom = 3'd1;
    @(negedge clk);
    cmd_alg = ALG_DEC; cmd_zoom = 3'd2;
    check("cfg_c", {proc_alg, proc_zoom}, {ALG_PR, 3'd1});
    clear_phase(-1);
    check("cfg_c_stable", {proc_alg, proc_zoom, cmd_ready}, {ALG_PR, 3'd1, 1'b0});
    cmd_valid = 1'b0;
    launch_phase();
    foreach (wr_tab[i]) begin
      proc_write_addr = wr_tab[i].addr; proc_pixel = wr_tab[i].pix;
      @(negedge clk);
      check($sformatf("run_we_%0d", i), ram_we, wr_tab[i].exp_we);
      if (wr_tab[i].exp_we)
        check($sformatf("run_wr_%0d", i), {ram_wr_addr, ram_wr_data}, {wr_tab[i].addr, wr_tab[i].pix});
    end
    proc_write_addr = 19'd200;
    check("run_c_enable", {proc_enable, busy}, {1'b1, 1'b1});
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    bad = 0;
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (frame_done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("no_done_after_reset", bad, 0);

    // Frame D: datapath never finishes, watchdog fires after TO RUN cycles.
    cmd_valid = 1'b1; cmd_alg = ALG_DEC; cmd_zoom = 3'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    clear_phase(-1);
    launch_phase();
    bad = 0;
    cyc = 0;
    while (frame_done !== 1'b1 && cyc < 400) begin
      if (proc_enable !== 1'b1) bad++;
      cyc++;
      @(negedge clk);
    end
    check("timeout_cycles", cyc, TO);
    check("timeout_enable", bad, 0);
    check("timeout_done", {frame_done, status, proc_enable, ram_we}, {1'b1, ST_TIMEOUT, 1'b0, 1'b0});
    @(negedge clk);
    check("timeout_idle", {frame_done, busy, proc_enable, status}, {1'b0, 1'b0, 1'b0, ST_TIMEOUT});

    // Abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk);
    check("abort_in_idle", {busy, frame_done, status}, {1'b0, 1'b0, ST_TIMEOUT});
    abort = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
